// File: rtl/melody_pkg.sv
// Shared note encoding, melody ROM size and sequencer state type.
// Imported by the JukeBox ROM and by the melody player.
package melody_pkg;

    typedef enum logic [3:0] {
        do_    = 4'h0,
        do_s   = 4'h1,
        re     = 4'h2,
        re_s   = 4'h3,
        mi     = 4'h4,
        fa     = 4'h5,
        fa_s   = 4'h6,
        sol    = 4'h7,
        sol_s  = 4'h8,
        la     = 4'h9,
        la_s   = 4'hA,
        si     = 4'hB,
        do_H   = 4'hC,
        do_s_H = 4'hD,
        re_H   = 4'hE,
        silence = 4'hF
    } musicNote;

    localparam int unsigned MAX_NOTES = 32;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StPlay,
        StGap,
        StDone
    } state_e;

endpackage

// File: rtl/melody_player_beat_timer.sv
// Note duration timer: BEAT_CLKS prescaler feeding a beat down-counter loaded with the
// note length; flags the clock on which the final beat of the note completes.
module beat_timer #(
    parameter int unsigned BEAT_CLKS = 6_250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] note_length,
    input  logic       tick,
    output logic       last_beat_done
);
    localparam int unsigned TickW = (BEAT_CLKS > 1) ? $clog2(BEAT_CLKS) : 1;

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic             wrap;

    assign wrap           = tick && (tick_cnt_q == TickW'(BEAT_CLKS - 1));
    assign last_beat_done = wrap && (beat_cnt_q == 4'd1);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (load) begin
            tick_cnt_d = '0;
            beat_cnt_d = note_length;
        end else if (wrap) begin
            tick_cnt_d = '0;
            beat_cnt_d = beat_cnt_q - 4'd1;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: walks the JukeBox ROM note by note, times each note in beats,
// inserts a silent articulation gap and reports completion with a one-cycle pulse.
module melody_player
    import melody_pkg::*;
#(
    parameter int unsigned BEAT_CLKS = 6_250_000,
    parameter int unsigned GAP_CLKS  = 1_000_000,
    parameter int unsigned SEL_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startMelody,
    input  logic             stopMelody,
    input  logic [SEL_W-1:0] melodySelectIn,
    input  logic [3:0]       tone,
    input  logic [3:0]       note_length,
    input  logic             silenceOutN,
    output logic [SEL_W-1:0] melodySelect,
    output logic [4:0]       noteIndex,
    output logic [3:0]       toneOut,
    output logic             enableSound,
    output logic             busy,
    output logic             melodyDone
);
    localparam int unsigned GapW    = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [4:0]  LastIdx = 5'(MAX_NOTES - 1);

    state_e           state_q, state_d, after_note;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [4:0]       idx_q, idx_d;
    logic [3:0]       tone_q, tone_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             silent_q, silent_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             restart, load, play_tick, last_beat_done, gap_last;

    assign restart   = startMelody && !stopMelody;
    assign load      = (state_q == StFetch) && (note_length != 4'd0);
    assign play_tick = (state_q == StPlay);
    assign gap_last  = (gap_q == GapW'(1));
    // Note 31 is the last ROM slot: finish instead of wrapping the address.
    assign after_note = (idx_q == LastIdx) ? StDone : StFetch;

    beat_timer #(
        .BEAT_CLKS(BEAT_CLKS)
    ) u_beat_timer (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .note_length   (note_length),
        .tick          (play_tick),
        .last_beat_done(last_beat_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            idx_q    <= '0;
            tone_q   <= '0;
            gap_q    <= '0;
            silent_q <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            tone_q   <= tone_d;
            gap_q    <= gap_d;
            silent_q <= silent_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StIdle;
            StFetch: state_d = (note_length == 4'd0) ? StDone : StPlay;
            StPlay: begin
                if (last_beat_done) state_d = (GAP_CLKS == 0) ? after_note : StGap;
            end
            StGap: begin
                if (gap_last) state_d = after_note;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (restart) state_d = StFetch;
        if (stopMelody) state_d = StIdle;
    end

    always_comb begin
        sel_d    = sel_q;
        idx_d    = idx_q;
        tone_d   = tone_q;
        gap_d    = gap_q;
        silent_d = silent_q;
        if (stopMelody) begin
            idx_d = '0;
        end else if (restart) begin
            sel_d = melodySelectIn;
            idx_d = '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (note_length != 4'd0) begin
                        tone_d   = tone;
                        silent_d = !silenceOutN;
                    end
                end
                StPlay: begin
                    if (last_beat_done) begin
                        if (GAP_CLKS != 0) begin
                            gap_d = GapW'(GAP_CLKS);
                        end else if (idx_q != LastIdx) begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                StGap: begin
                    if (!gap_last) begin
                        gap_d = gap_q - GapW'(1);
                    end else if (idx_q != LastIdx) begin
                        idx_d = idx_q + 5'd1;
                    end
                end
                StDone:  idx_d = '0;
                default: idx_d = idx_q;
            endcase
        end
        en_d   = (state_d == StPlay) && !silent_d;
        done_d = (state_d == StDone);
    end

    assign melodySelect = sel_q;
    assign noteIndex    = idx_q;
    assign toneOut      = tone_q;
    assign enableSound  = en_q;
    assign melodyDone   = done_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player with a stub JukeBox ROM (BEAT_CLKS=4, GAP_CLKS=2).
// Stimulus queues expected per-cycle outputs and melodyDone cycles; a monitor checks them.
module tb_melody_player;
    import melody_pkg::*;

    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam logic [3:0] ScaleTone [9] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h7, 4'h9, 4'hB, 4'hC, 4'hE};
    localparam logic [3:0] ScaleLen  [9] = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd4};

    logic       clk = 1'b0;
    logic       reset, startMelody, stopMelody, silenceOutN;
    logic [3:0] melodySelectIn, tone, note_length, melodySelect, toneOut;
    logic [4:0] noteIndex;
    logic       enableSound, busy, melodyDone;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [4:0] idx;
        logic [3:0] tone;
        logic       en;
        logic       busy;
        logic [3:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];

    melody_player #(
        .BEAT_CLKS(BEAT),
        .GAP_CLKS (GAP),
        .SEL_W    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .startMelody   (startMelody),
        .stopMelody    (stopMelody),
        .melodySelectIn(melodySelectIn),
        .tone          (tone),
        .note_length   (note_length),
        .silenceOutN   (silenceOutN),
        .melodySelect  (melodySelect),
        .noteIndex     (noteIndex),
        .toneOut       (toneOut),
        .enableSound   (enableSound),
        .busy          (busy),
        .melodyDone    (melodyDone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub JukeBox, returns {note_length, tone, silenceOutN}.
    function automatic logic [8:0] jb(input logic [3:0] sel, input logic [4:0] idx);
        logic [3:0] len;
        logic [3:0] tn;
        logic       sn;
        len = 4'd0;
        tn  = 4'h0;
        sn  = 1'b1;
        case (sel)
            4'd0: if (idx < 5'd3) begin
                len = 4'd1;
                tn  = (idx == 5'd0) ? 4'h0 : (idx == 5'd1) ? 4'h2 : 4'h4;
            end
            4'd1: if (idx < 5'd2) begin
                len = 4'd1;
                tn  = (idx == 5'd0) ? 4'h4 : 4'h5;
            end
            4'd2: if (idx < 5'd9) begin
                len = ScaleLen[int'(idx)];
                tn  = ScaleTone[int'(idx)];
            end
            4'd13: begin
                if (idx < 5'd3) begin
                    len = 4'd1;
                    tn  = 4'h7;
                end else if (idx == 5'd3) begin
                    len = 4'd3;
                    tn  = 4'hF;
                    sn  = 1'b0;
                end else if (idx < 5'd7) begin
                    len = 4'd3;
                    tn  = 4'h7;
                end
            end
            4'd15: begin
                len = 4'd1;
                tn  = idx[3:0];
            end
            default: len = 4'd0;
        endcase
        return {len, tn, sn};
    endfunction

    assign {note_length, tone, silenceOutN} = jb(melodySelect, noteIndex);

    function automatic void push_exp(int c, logic [4:0] i, logic [3:0] t, logic e, logic b,
                                     logic [3:0] s);
        exp_t x;
        x.cyc  = c;
        x.idx  = i;
        x.tone = t;
        x.en   = e;
        x.busy = b;
        x.sel  = s;
        exp_q.push_back(x);
    endfunction

    function automatic void push_done_end(int d, logic [4:0] i, logic [3:0] t, logic [3:0] s);
        push_exp(d, i, t, 1'b0, 1'b1, s);
        push_exp(d + 1, 5'd0, t, 1'b0, 1'b0, s);
        done_q.push_back(d);
    endfunction

    // f0: cycle in which FETCH of note 0 is visible. Each note is 1 + len*BEAT + GAP cycles.
    function automatic void expect_melody(int f0, logic [3:0] sel, int max_notes, bit with_done);
        int         f;
        int         len;
        logic [8:0] r;
        logic [3:0] tn;
        logic [3:0] last;
        logic       sn;
        f    = f0;
        last = 4'h0;
        for (int k = 0; k < 32; k++) begin
            r   = jb(sel, 5'(k));
            len = int'(r[8:5]);
            tn  = r[4:1];
            sn  = r[0];
            if (len == 0) begin
                if (with_done) push_done_end(f + 1, 5'(k), last, sel);
                return;
            end
            if (k >= max_notes) return;
            push_exp(f + 1, 5'(k), tn, sn, 1'b1, sel);
            push_exp(f + BEAT * len, 5'(k), tn, sn, 1'b1, sel);
            push_exp(f + BEAT * len + 1, 5'(k), tn, 1'b0, 1'b1, sel);
            last = tn;
            f += 1 + BEAT * len + GAP;
        end
        if (with_done) push_done_end(f, 5'd31, last, sel);
    endfunction

    // Monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t x;
            x = exp_q.pop_front();
            n_cmp++;
            if (x.cyc != cyc || noteIndex !== x.idx || toneOut !== x.tone ||
                enableSound !== x.en || busy !== x.busy || melodySelect !== x.sel) begin
                n_fail++;
                $display("FAIL outputs@%0d: got idx=%0d tone=%h en=%b busy=%b sel=%0d, want idx=%0d tone=%h en=%b busy=%b sel=%0d (due %0d)",
                         cyc, noteIndex, toneOut, enableSound, busy, melodySelect,
                         x.idx, x.tone, x.en, x.busy, x.sel, x.cyc);
            end
        end
        if (melodyDone !== 1'b0) begin
            int d;
            n_cmp++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL melodyDone: got pulse=%b at cycle %0d, want no pulse", melodyDone, cyc);
            end else begin
                d = done_q.pop_front();
                if (d != cyc) begin
                    n_fail++;
                    $display("FAIL melodyDone: got pulse at cycle %0d, want cycle %0d", cyc, d);
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start(input logic [3:0] s, output int f0);
        melodySelectIn = s;
        startMelody    = 1'b1;
        f0             = cyc + 1;
        @(negedge clk);
        startMelody = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by time %0t, want completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int f1;
        reset          = 1'b1;
        startMelody    = 1'b0;
        stopMelody     = 1'b0;
        melodySelectIn = 4'd0;
        @(negedge clk);
        push_exp(cyc + 1, 5'd0, 4'h0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-note: melody 2, note 2 PLAY spans f0+23..f0+30.
        start(4'd2, f0);
        expect_melody(f0, 4'd2, 2, 1'b0);
        push_exp(f0 + 24, 5'd2, 4'h4, 1'b1, 1'b1, 4'd2);
        wait_cyc(f0 + 24);
        @(posedge clk);
        #1 reset = 1'b1;
        push_exp(f0 + 25, 5'd0, 4'h0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_exp(cyc + 5, 5'd0, 4'h0, 1'b0, 1'b0, 4'd0);
        wait_cyc(cyc + 6);

        // Scale melody: DONE 116 cycles after the sampling edge.
        start(4'd2, f0);
        expect_melody(f0, 4'd2, 32, 1'b1);
        wait_cyc(f0 + 120);

        // SOS with a silent fourth note.
        start(4'd13, f0);
        expect_melody(f0, 4'd13, 32, 1'b1);
        wait_cyc(f0 + 90);

        // Stop in PLAY of note 5 with a simultaneous start that must be ignored.
        start(4'd2, f0);
        expect_melody(f0, 4'd2, 5, 1'b0);
        push_exp(f0 + 65, 5'd5, 4'h9, 1'b1, 1'b1, 4'd2);
        wait_cyc(f0 + 66);
        stopMelody     = 1'b1;
        startMelody    = 1'b1;
        melodySelectIn = 4'd7;
        push_exp(f0 + 67, 5'd0, 4'h9, 1'b0, 1'b0, 4'd2);
        push_exp(f0 + 70, 5'd0, 4'h9, 1'b0, 1'b0, 4'd2);
        @(negedge clk);
        stopMelody  = 1'b0;
        startMelody = 1'b0;
        wait_cyc(f0 + 72);

        // Restart into melody 1 during the first GAP cycle of melody 0.
        start(4'd0, f0);
        expect_melody(f0, 4'd0, 1, 1'b0);
        wait_cyc(f0 + 5);
        melodySelectIn = 4'd1;
        startMelody    = 1'b1;
        f1             = cyc + 1;
        push_exp(f1, 5'd0, 4'h0, 1'b0, 1'b1, 4'd1);
        expect_melody(f1, 4'd1, 32, 1'b1);
        @(negedge clk);
        startMelody = 1'b0;
        wait_cyc(f1 + 20);

        // All 32 slots populated: DONE after index 31, no wrap.
        start(4'd15, f0);
        expect_melody(f0, 4'd15, 32, 1'b1);
        wait_cyc(f0 + 32 * (1 + BEAT + GAP) + 6);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL exp_queue: got %0d unchecked entries, want 0", exp_q.size());
        end
        n_cmp++;
        if (done_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_queue: got %0d missing pulses, want 0", done_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
